// File: rtl/load_store_unit_pkg.sv
// Shared size codes, FSM state encoding and alignment rule for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] LSU_SIZE_BYTE = 2'd0;
  localparam logic [1:0] LSU_SIZE_HALF = 2'd1;
  localparam logic [1:0] LSU_SIZE_WORD = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_READ  = 2'd1,
    LSU_WRITE = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_t;

  // Size code 2 has no meaning of its own and follows the word rule.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      LSU_SIZE_BYTE: return 1'b0;
      LSU_SIZE_HALF: return addr_lo[0];
      default:       return addr_lo != 2'b00;
    endcase
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
interface load_store_unit_if #(parameter int ADDR_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_misaligned;
  logic                  rsp_error;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_error,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_error,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte/half lane selection: extends load data and merges sub-word store data into a word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte       = 8'(i_word >> {i_addr_lo, 3'b000});
    w_half       = 16'(i_word >> {i_addr_lo[1], 4'b0000});
    o_load_data  = i_word;
    o_store_word = i_word;
    case (i_size)
      LSU_SIZE_BYTE: begin
        o_load_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      end
      LSU_SIZE_HALF: begin
        o_load_data = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata;
      end
      default: begin
        o_load_data  = i_word;
        o_store_word = i_word;
      end
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store responder: one access per request, RMW for sub-word stores.
// state | meaning
// IDLE  | ready for a request
// READ  | memory read (load, or first half of a sub-word store)
// WRITE | memory write (word store, or merged word of a sub-word store)
// RESP  | one-cycle completion pulse on rsp_valid
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave bus
);
  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  lsu_state_t            r_state;
  logic                  r_write;
  logic                  r_unsigned;
  logic [1:0]            r_size;
  logic [1:0]            r_addr_lo;
  logic [ADDR_WIDTH-3:0] r_word_addr;
  logic [15:0]           r_wdata;
  logic [31:0]           r_wword;
  logic [CW-1:0]         r_cnt;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-3:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_mis;
  logic                  r_rsp_err;

  logic                  w_word_size;
  logic [31:0]           w_load_data;
  logic [31:0]           w_store_word;

  assign w_word_size = (bus.req_size == LSU_SIZE_WORD) || (bus.req_size == 2'd2);

  lsu_lane_align u_align (
    .i_addr_lo    (r_addr_lo),
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_word       (bus.mem_rdata),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  // First cycle of READ/WRITE issues the request; the wait counter runs while it is outstanding.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= LSU_IDLE;
      r_write     <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'd0;
      r_addr_lo   <= 2'd0;
      r_word_addr <= '0;
      r_wdata     <= 16'h0;
      r_wword     <= 32'h0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_mis   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (bus.req_valid) begin
            r_write     <= bus.req_write;
            r_unsigned  <= bus.req_unsigned;
            r_size      <= bus.req_size;
            r_addr_lo   <= bus.req_addr[1:0];
            r_word_addr <= bus.req_addr[ADDR_WIDTH-1:2];
            r_wdata     <= bus.req_wdata[15:0];
            r_wword     <= bus.req_wdata;
            r_cnt       <= '0;
            if (lsu_misaligned(bus.req_size, bus.req_addr[1:0])) begin
              r_rsp_valid <= 1'b1;
              r_rsp_mis   <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= 32'h0;
              r_state     <= LSU_RESP;
            end else if (bus.req_write && w_word_size) begin
              r_state <= LSU_WRITE;
            end else begin
              r_state <= LSU_READ;
            end
          end
        end
        LSU_READ: begin
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_word_addr;
          end else if (bus.mem_ack) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            if (r_write) begin
              r_wword <= w_store_word;
              r_cnt   <= '0;
              r_state <= LSU_WRITE;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_load_data;
              r_state     <= LSU_RESP;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= LSU_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LSU_WRITE: begin
          if (!r_mem_req) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_word_addr;
            r_mem_wdata <= r_wword;
          end else if (bus.mem_ack || (r_cnt == CNT_LAST)) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !bus.mem_ack;
            r_state     <= LSU_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LSU_RESP: begin
          r_rsp_rdata <= 32'h0;
          r_rsp_mis   <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_state     <= LSU_IDLE;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (r_state == LSU_IDLE);
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;
  assign bus.rsp_misaligned = r_rsp_mis;
  assign bus.rsp_error      = r_rsp_err;
  assign bus.mem_req        = r_mem_req;
  assign bus.mem_we         = r_mem_we;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wdata      = r_mem_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a word-array reference model.
module tb_load_store_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32), .ACK_TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct { logic [31:0] rdata; logic mis; logic err; } exp_t;
  typedef struct { logic [29:0] a; logic [31:0] d; } wr_t;

  exp_t sbq[$];
  wr_t  wq[$];
  int   start_q[$], ack_q[$], we_q[$];

  logic [31:0] ref_mem [256];
  logic [31:0] dut_mem [256];

  int total = 0, bad = 0;
  int cyc = 0;
  int rsp_count = 0, last_rsp_cyc = 0, req_hi = 0;
  int fixed_wait = 0;
  bit block_all_ack = 0, block_wr_ack = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: memory as a plain word array, lanes via shifts and masks.
  task automatic model_push(input bit w, input bit [1:0] sz, input bit u,
                            input bit [31:0] a, input bit [31:0] wd, input bit timeout);
    exp_t e;
    int idx, sh, nbytes;
    bit [31:0] word, mask, v;
    idx = int'(a[9:2]);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.rdata = 32'h0; e.mis = 1'b0; e.err = 1'b0;
    if (a % nbytes != 0) e.mis = 1'b1;
    else if (timeout) e.err = 1'b1;
    else begin
      word = ref_mem[idx];
      sh   = 8 * int'(a % 4);
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
      if (w) begin
        word = (word & ~(mask << sh)) | ((wd & mask) << sh);
        ref_mem[idx] = word;
        wq.push_back('{a: a[31:2], d: word});
      end else begin
        v = (word >> sh) & mask;
        if (!u && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
        e.rdata = v;
      end
    end
    sbq.push_back(e);
  endtask

  task automatic drive(input bit w, input bit [1:0] sz, input bit u,
                       input bit [31:0] a, input bit [31:0] wd, output int acc);
    int n = 0;
    bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
    bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 200) begin @(posedge clock); #1; n++; end
    chk("req_ready_wait", bus.req_ready, 1);
    @(posedge clock); #1;
    acc = cyc;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_unsigned = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_count < target && n < 400) begin @(posedge clock); #1; n++; end
    chk("rsp_wait", rsp_count, target);
  endtask

  task automatic do_req(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                        input bit [31:0] wd, input bit timeout, input int exp_lat);
    int acc, tgt;
    tgt = rsp_count + 1;
    model_push(w, sz, u, a, wd, timeout);
    drive(w, sz, u, a, wd, acc);
    wait_rsp(tgt);
    if (exp_lat > 0) chk("latency", last_rsp_cyc - acc + 1, exp_lat);
  endtask

  // Memory responder with configurable wait states.
  initial begin
    bit busy = 0;
    int wait_left = 0;
    wr_t e;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clock); #1;
      if (bus.mem_ack || bus.mem_req !== 1'b1) begin
        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom; busy = 0;
      end else begin
        req_hi++;
        if (!busy) begin
          busy = 1;
          wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
          start_q.push_back(cyc); we_q.push_back(int'(bus.mem_we));
        end
        if (wait_left == 0 && !block_all_ack && !(block_wr_ack && bus.mem_we)) begin
          bus.mem_ack = 1'b1; ack_q.push_back(cyc);
          if (bus.mem_we) begin
            if (wq.size() == 0) chk("wr_unexpected", bus.mem_we, 0);
            else begin
              e = wq.pop_front();
              chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
              chk("wr_data", bus.mem_wdata, e.d);
            end
            dut_mem[bus.mem_addr[7:0]] = bus.mem_wdata;
          end else bus.mem_rdata = dut_mem[bus.mem_addr[7:0]];
        end else if (wait_left > 0) wait_left--;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.rsp_valid === 1'b1) begin
        rsp_count++; last_rsp_cyc = cyc;
        if (sbq.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
        else begin
          e = sbq.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_misaligned", bus.rsp_misaligned, e.mis);
          chk("rsp_error", bus.rsp_error, e.err);
        end
      end
    end
  end

  initial begin
    int acc, n0, n;
    bit w, u; bit [1:0] sz; bit [31:0] a, wd;
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = $urandom; dut_mem[i] = ref_mem[i]; end

    repeat (3) @(posedge clock); #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_req_ready", bus.req_ready, 1);

    fixed_wait = 0;
    do_req(1, 2'd3, 0, 32'h100, 32'hDEADBEEF, 0, 3);
    fixed_wait = 2;
    do_req(0, 2'd3, 0, 32'h100, 32'h0, 0, 5);

    fixed_wait = 0;
    ref_mem[128] = 32'h80F07F01; dut_mem[128] = 32'h80F07F01;
    do_req(0, 2'd0, 0, 32'h203, 32'h0, 0, 3);
    do_req(0, 2'd0, 1, 32'h203, 32'h0, 0, 3);
    do_req(0, 2'd1, 0, 32'h202, 32'h0, 0, 3);
    do_req(0, 2'd1, 1, 32'h200, 32'h0, 0, 3);

    ref_mem[128] = 32'h11223344; dut_mem[128] = 32'h11223344;
    start_q.delete(); ack_q.delete(); we_q.delete();
    do_req(1, 2'd0, 0, 32'h201, 32'h55, 0, 5);
    chk("rmw_txns", we_q.size(), 2);
    chk("rmw_first_read", we_q[0], 0);
    chk("rmw_then_write", we_q[1], 1);
    chk("rmw_gap", start_q[1] - ack_q[0] - 1, 1);
    chk("rmw_merged", dut_mem[128], 32'h11225544);

    req_hi = 0;
    do_req(0, 2'd3, 0, 32'h102, 32'h0, 0, 1);
    do_req(1, 2'd1, 0, 32'h301, 32'hBEEF, 0, 1);
    chk("mis_no_mem_req", req_hi, 0);

    block_all_ack = 1; req_hi = 0;
    do_req(0, 2'd3, 0, 32'h100, 32'h0, 1, 0);
    block_all_ack = 0;
    chk("timeout_req_cycles", req_hi, 16);
    chk("timeout_idle", bus.req_ready, 1);

    block_wr_ack = 1; n0 = rsp_count; n = 0;
    drive(1, 2'd0, 0, 32'h244, 32'hA5, acc);
    while (!(bus.mem_req && bus.mem_we) && n < 50) begin @(posedge clock); #1; n++; end
    chk("reset_in_write", bus.mem_we, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("reset_mem_req", bus.mem_req, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("reset_ready", bus.req_ready, 1);
    repeat (5) @(posedge clock);
    #1;
    chk("reset_no_rsp", rsp_count, n0);
    block_wr_ack = 0;
    do_req(0, 2'd3, 0, 32'h244, 32'h0, 0, 3);

    fixed_wait = -1;
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom); sz = 2'($urandom); u = 1'($urandom);
      a = $urandom_range(0, 1023); wd = $urandom;
      model_push(w, sz, u, a, wd, 0);
      drive(w, sz, u, a, wd, acc);
    end
    n = 0;
    while (sbq.size() != 0 && n < 400) begin @(posedge clock); #1; n++; end
    repeat (3) @(posedge clock);
    #1;
    chk("sb_drained", sbq.size(), 0);
    chk("wq_drained", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
